// File: rtl/fixedpoint_polar2cart.sv
// Fully pipelined CORDIC rotation: polar (r, angle) in Q32.32 -> cartesian (r*cos, r*sin).
// Defining FIXEDPOINT_POLAR2CART_RANGE_ERR_EN adds a range_err output flagging |angle| > pi.
module fixedpoint_polar2cart #(
    parameter int WIDTH = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic signed [64:0] r,
    input  logic signed [64:0] angle,
    output logic signed [64:0] x,
    output logic signed [64:0] y,
`ifdef FIXEDPOINT_POLAR2CART_RANGE_ERR_EN
    output logic               range_err,
`endif
    output logic               out_valid
);
    localparam logic signed [64:0] PI_C          = 65'sh3_243F_6A89;
    localparam logic signed [64:0] NEG_PI_C      = -PI_C;
    localparam logic signed [64:0] PI_HALF_C     = 65'sh1_921F_B544;
    localparam logic signed [64:0] NEG_PI_HALF_C = -PI_HALF_C;
    localparam logic signed [32:0] K_C           = 33'sh9B74_EDA8;

    // atan(2^-i) in Q32.32; past i = 10 the cubic term is below one LSB.
    function automatic logic signed [64:0] atan_entry(input int idx);
        case (idx)
            0:       atan_entry = 65'shC90F_DAA2;
            1:       atan_entry = 65'sh76B1_9C16;
            2:       atan_entry = 65'sh3EB6_EBF2;
            3:       atan_entry = 65'sh1FD5_BA9B;
            4:       atan_entry = 65'sh0FFA_ADDC;
            5:       atan_entry = 65'sh07FF_556F;
            6:       atan_entry = 65'sh03FF_EAAB;
            7:       atan_entry = 65'sh01FF_FD55;
            8:       atan_entry = 65'sh00FF_FFAB;
            9:       atan_entry = 65'sh007F_FFF5;
            10:      atan_entry = 65'sh003F_FFFF;
            default: atan_entry = 65'sd1 <<< (32 - idx);
        endcase
    endfunction

    logic signed [97:0] prod_s;
    logic signed [64:0] rk_s;
    logic signed [64:0] x_q [0:WIDTH];
    logic signed [64:0] x_d [0:WIDTH];
    logic signed [64:0] y_q [0:WIDTH];
    logic signed [64:0] y_d [0:WIDTH];
    logic signed [64:0] z_q [0:WIDTH-1];
    logic signed [64:0] z_d [0:WIDTH-1];
    logic [WIDTH:0]     v_q;
    logic [WIDTH:0]     v_d;
    logic signed [64:0] xo_q;
    logic signed [64:0] xo_d;
    logic signed [64:0] yo_q;
    logic signed [64:0] yo_d;
    logic               vo_q;
    logic               vo_d;

    // Stage 0 gain pre-scale and quadrant fold, then the micro-rotation chain.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        prod_s = 98'(r) * 98'(K_C);
        rk_s   = 65'(prod_s >>> 32);
        y_d[0] = 65'sd0;
        if (angle > PI_HALF_C) begin
            x_d[0] = -rk_s;
            z_d[0] = angle - PI_C;
        end else if (angle < NEG_PI_HALF_C) begin
            x_d[0] = -rk_s;
            z_d[0] = angle + PI_C;
        end else begin
            x_d[0] = rk_s;
            z_d[0] = angle;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (z_q[i][64] == 1'b0) begin
                x_d[i+1] = x_q[i] - (y_q[i] >>> i);
                y_d[i+1] = y_q[i] + (x_q[i] >>> i);
            end else begin
                x_d[i+1] = x_q[i] + (y_q[i] >>> i);
                y_d[i+1] = y_q[i] - (x_q[i] >>> i);
            end
        end
        // The last stage only needs the sign of z, so z stops one stage early.
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (z_q[i][64] == 1'b0) begin
                z_d[i+1] = z_q[i] - atan_entry(i);
            end else begin
                z_d[i+1] = z_q[i] + atan_entry(i);
            end
        end
    end

    // Valid chain and output stage next-state.
    always_comb begin
        v_d  = {v_q[WIDTH-1:0], in_valid};
        vo_d = v_q[WIDTH];
        xo_d = x_q[WIDTH];
        yo_d = y_q[WIDTH];
    end

    // Control state: valid bits and output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q  <= {(WIDTH+1){1'b0}};
            vo_q <= 1'b0;
            xo_q <= 65'sd0;
            yo_q <= 65'sd0;
        end else begin
            v_q  <= v_d;
            vo_q <= vo_d;
            xo_q <= xo_d;
            yo_q <= yo_d;
        end
    end

    // Datapath registers run free; stale contents are masked by the valid chain.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
    end

    // Outputs read as zero whenever no result is presented.
    always_comb begin
        out_valid = vo_q;
        if (vo_q) begin
            x = xo_q;
            y = yo_q;
        end else begin
            x = 65'sd0;
            y = 65'sd0;
        end
    end

`ifdef FIXEDPOINT_POLAR2CART_RANGE_ERR_EN
    logic [WIDTH:0] rf_q;
    logic [WIDTH:0] rf_d;
    logic           ro_q;
    logic           ro_d;

    // Out-of-range flag rides alongside the sample.
    always_comb begin
        rf_d = {rf_q[WIDTH-1:0], (angle > PI_C) || (angle < NEG_PI_C)};
        ro_d = rf_q[WIDTH];
    end

    // Flag pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_q <= {(WIDTH+1){1'b0}};
            ro_q <= 1'b0;
        end else begin
            rf_q <= rf_d;
            ro_q <= ro_d;
        end
    end

    assign range_err = ro_q & vo_q;
`endif
endmodule

// File: doc/fixedpoint_polar2cart.md
Name: fixedpoint_polar2cart

Overview:
- CORDIC rotation-mode converter. Takes a polar pair (radius r, angle) and produces cartesian (x, y) = (r·cos(angle), r·sin(angle)).
- Inverse of the atan2/magnitude vectoring block.
- Used in the ray/geometry datapath wherever a direction or point is rebuilt from angle and length.
- Fully pipelined with no backpressure: accepts one sample per cycle and returns results in order.

Parameters:
- WIDTH, 28, number of CORDIC iterations (1..28). Sets latency and accuracy. The arctan table holds 28 entries; entry i = atan(2^-i) in Q32.32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  r/angle valid this cycle.
- r  in  65 (fixedpoint::number)  radius, signed Q32.32 two's complement, bit 64 = sign.
- angle  in  65 (fixedpoint::number)  angle in radians, Q32.32, legal range [-pi, +pi].
- x  out  65 (fixedpoint::number)  r·cos(angle).
- y  out  65 (fixedpoint::number)  r·sin(angle).
- out_valid  out  1  x/y valid this cycle.

Behaviour:
- Number format:
  - fixedpoint::number is 65-bit signed Q32.32.
  - All shifts are arithmetic (>>>).
  - Add/sub wrap at 65 bits; no saturation.
- Reset (rst_n low at clk edge):
  - Every stage valid bit clears; out_valid = 0, x = 0, y = 0.
  - Datapath registers need not clear.
  - in_valid during a reset cycle is ignored.
  - Samples in flight are discarded and never emerge.
- Pipeline:
  - Free-running; stages advance every cycle regardless of in_valid.
  - Each stage carries its own valid bit, so bubbles propagate with the data.
- Stage 0 (scale + quadrant reduction), registered:
  - rk = (r · K) >>> 32, where K = 0x9B74EDA8 (Q0.32, ≈0.6072529). Signed product truncated toward -inf.
  - angle > pi/2: x0 = -rk, y0 = 0, z0 = angle - pi.
  - angle < -pi/2: x0 = -rk, y0 = 0, z0 = angle + pi.
  - otherwise: x0 = rk, y0 = 0, z0 = angle.
  - Exactly ±pi/2 takes the "otherwise" branch.
  - pi and pi/2 are the nearest Q32.32 values.
- Stages 1..WIDTH (iteration i = 0..WIDTH-1), registered:
  - d = +1 if z[i] ≥ 0 (bit 64 = 0), else -1.
  - x[i+1] = x[i] - d·(y[i] >>> i)
  - y[i+1] = y[i] + d·(x[i] >>> i)
  - z[i+1] = z[i] - d·atan_table[i]
- Output stage: registers x[WIDTH] and y[WIDTH] together with the valid bit.
- Latency: exactly WIDTH+2 cycles, in_valid edge to out_valid edge (30 at default). Throughput is 1 sample per cycle.
- Output gating: while out_valid = 0, x and y are driven to 0 (combinational gating after the output register).
- Accuracy: for |r| ≤ 2^16 and legal angle, |error| ≤ 2^-20·max(1, |r|) per component.
- Boundary cases:
  - r = 0 gives exactly (0, 0).
  - Negative r yields the mirrored point (-|r|cos, -|r|sin).
  - |r| ≥ 2^31 may overflow; the result is unspecified.
  - angle outside [-pi, pi] gives an unspecified result (see the optional feature).

Optional Feature:
- Macro: FIXEDPOINT_POLAR2CART_RANGE_ERR_EN.
- Defined:
  - Adds output port range_err (1 bit).
  - Stage 0 flags angle > pi or angle < -pi.
  - The flag travels with the sample; range_err = flag AND out_valid.
  - range_err resets to 0.
  - x/y for a flagged sample are still computed, but are unspecified.
- Undefined: the port and all associated logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then one pulse with r = 1.0, angle = 0 → out_valid high for exactly one cycle, 30 cycles later; x = 1.0 ± 2^-20, y = 0 ± 2^-20. Outputs are 0 in every other cycle.
- r = 2.0, angle = pi/2 → x = 0 ± 2^-19, y = 2.0 ± 2^-19.
- r = 1.0, angle = -3pi/4 (lower-quadrant reduction) → x = y = -0.7071068 ± 2^-20. Also angle = 3pi/4 → x = -0.7071068, y = +0.7071068.
- Stream of 40 samples with angle_k = -pi + k·(2pi/40), r = 3.5, with in_valid bubbles on k = 5, 6, 20:
  - out_valid reproduces the input valid pattern delayed by 30 cycles.
  - Results emerge in order and match the reference model within tolerance.
- Issue 10 back-to-back samples, then assert rst_n = 0 for 1 cycle at cycle 15 → no out_valid after the reset. A new sample sent after reset returns correctly 30 cycles later.
- (Macro defined) angle = 3.5 with r = 1 → range_err = 1 coincident with out_valid. angle = 3.0 → range_err = 0.
